// File: rtl/mdu_pkg.sv
// Shared definitions for the multiply/divide unit: op encoding, default latencies and
// the 64-bit product helper.
package mdu_pkg;

  typedef enum logic [3:0] {
    OpNone  = 4'd0,
    OpMult  = 4'd1,
    OpMultu = 4'd2,
    OpDiv   = 4'd3,
    OpDivu  = 4'd4,
    OpMthi  = 4'd5,
    OpMtlo  = 4'd6,
    OpMfhi  = 4'd7,
    OpMflo  = 4'd8,
    OpMadd  = 4'd9,
    OpMaddu = 4'd10,
    OpMsub  = 4'd11,
    OpMsubu = 4'd12
  } op_e;

  localparam int unsigned MultLatDefault = 5;
  localparam int unsigned DivLatDefault  = 10;

  // Full 64-bit product; operands are extended to 64 bits so the low 64 bits are exact.
  function automatic logic [63:0] mul64(input logic [31:0] a, input logic [31:0] b,
                                        input logic is_signed);
    logic [63:0] a_ext;
    logic [63:0] b_ext;
    a_ext = {{32{is_signed & a[31]}}, a};
    b_ext = {{32{is_signed & b[31]}}, b};
    return a_ext * b_ext;
  endfunction

endpackage

// File: rtl/mdu.sv
// E-stage multiply/divide unit holding HI/LO; results commit after a fixed latency.
// Optional MADD/MADDU/MSUB/MSUBU support is enabled with the MDU_MADD_EN macro.
module mdu
  import mdu_pkg::*;
#(
  parameter int unsigned MULT_LAT = MultLatDefault,
  parameter int unsigned DIV_LAT  = DivLatDefault
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [3:0]  op,
  input  logic        cancel,
  input  logic [31:0] A,
  input  logic [31:0] B,
  output logic        busy,
  output logic [31:0] MD,
  output logic [31:0] HI,
  output logic [31:0] LO
);

  localparam int unsigned MaxLat = (MULT_LAT > DIV_LAT) ? MULT_LAT : DIV_LAT;
  localparam int unsigned CntW   = $clog2(MaxLat + 1);

  logic [CntW-1:0] cnt_q, cnt_d;
  logic [31:0]     tmp_hi_q, tmp_hi_d;
  logic [31:0]     tmp_lo_q, tmp_lo_d;
  logic [31:0]     hi_q, hi_d;
  logic [31:0]     lo_q, lo_d;

  logic        accept;
  logic        mul_signed;
  logic        div_signed;
  logic        div_by_zero;
  logic [63:0] prod;
  logic [31:0] div_b;
  logic [31:0] quot;
  logic [31:0] rem;

  assign busy   = (cnt_q != '0);
  assign accept = start & ~cancel & ~busy;

  assign mul_signed  = (op == OpMult) | (op == OpMadd) | (op == OpMsub);
  assign div_signed  = (op == OpDiv);
  assign div_by_zero = (B == 32'd0);
  assign prod        = mul64(A, B, mul_signed);

  // Dividing by 1 covers both the zero divisor and the signed overflow case
  // (0x80000000 / -1), which must yield quotient 0x80000000 and remainder 0.
  always_comb begin
    div_b = B;
    if (div_by_zero || (div_signed && A == 32'h8000_0000 && B == 32'hFFFF_FFFF)) begin
      div_b = 32'd1;
    end
    if (div_signed) begin
      quot = $unsigned($signed(A) / $signed(div_b));
      rem  = $unsigned($signed(A) % $signed(div_b));
    end else begin
      quot = A / div_b;
      rem  = A % div_b;
    end
  end

  always_comb begin
    cnt_d    = cnt_q;
    tmp_hi_d = tmp_hi_q;
    tmp_lo_d = tmp_lo_q;
    hi_d     = hi_q;
    lo_d     = lo_q;

    if (busy) begin
      cnt_d = cnt_q - CntW'(1);
      if (cnt_q == CntW'(1)) begin
        hi_d = tmp_hi_q;
        lo_d = tmp_lo_q;
      end
    end else if (accept) begin
      case (op)
        OpMult, OpMultu: begin
          {tmp_hi_d, tmp_lo_d} = prod;
          cnt_d                = CntW'(MULT_LAT);
        end
        OpDiv, OpDivu: begin
          // A zero divisor still occupies the unit but commits the current HI/LO.
          if (div_by_zero) begin
            tmp_hi_d = hi_q;
            tmp_lo_d = lo_q;
          end else begin
            tmp_hi_d = rem;
            tmp_lo_d = quot;
          end
          cnt_d = CntW'(DIV_LAT);
        end
        OpMthi: hi_d = A;
        OpMtlo: lo_d = A;
`ifdef MDU_MADD_EN
        OpMadd, OpMaddu: begin
          {tmp_hi_d, tmp_lo_d} = {hi_q, lo_q} + prod;
          cnt_d                = CntW'(MULT_LAT);
        end
        OpMsub, OpMsubu: begin
          {tmp_hi_d, tmp_lo_d} = {hi_q, lo_q} - prod;
          cnt_d                = CntW'(MULT_LAT);
        end
`endif
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q    <= '0;
      tmp_hi_q <= '0;
      tmp_lo_q <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
    end else begin
      cnt_q    <= cnt_d;
      tmp_hi_q <= tmp_hi_d;
      tmp_lo_q <= tmp_lo_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
    end
  end

  assign HI = hi_q;
  assign LO = lo_q;
  assign MD = (op == OpMflo) ? lo_q : hi_q;

endmodule

// File: tb/tb_mdu.sv
// Self-checking bench for mdu: table-driven vectors with a scoreboard queue, plus
// hand-written sequences for start-while-busy, cancel and asynchronous reset.
module tb_mdu;

  localparam logic [3:0] NONE  = 4'd0;
  localparam logic [3:0] MULT  = 4'd1;
  localparam logic [3:0] MULTU = 4'd2;
  localparam logic [3:0] DIV   = 4'd3;
  localparam logic [3:0] DIVU  = 4'd4;
  localparam logic [3:0] MTHI  = 4'd5;
  localparam logic [3:0] MTLO  = 4'd6;
  localparam logic [3:0] MFHI  = 4'd7;
  localparam logic [3:0] MFLO  = 4'd8;
  localparam logic [3:0] MADDU = 4'd10;
  localparam logic [3:0] MSUB  = 4'd11;

`ifdef MDU_MADD_EN
  localparam bit MaddEn = 1'b1;
`else
  localparam bit MaddEn = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [3:0]  op;
  logic        cancel;
  logic [31:0] A;
  logic [31:0] B;
  logic        busy;
  logic [31:0] MD;
  logic [31:0] HI;
  logic [31:0] LO;

  mdu dut (
    .clk    (clk),
    .reset  (reset),
    .start  (start),
    .op     (op),
    .cancel (cancel),
    .A      (A),
    .B      (B),
    .busy   (busy),
    .MD     (MD),
    .HI     (HI),
    .LO     (LO)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [3:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] pre_hi;
    logic [31:0] pre_lo;
    logic [31:0] exp_hi;
    logic [31:0] exp_lo;
    int          lat;
  } vec_t;

  typedef struct {
    string       name;
    logic [31:0] hi;
    logic [31:0] lo;
    int          lat;
  } exp_t;

  vec_t vecs[13];
  exp_t sb[$];
  int   n_cmp = 0;
  int   n_err = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Present one op across a single rising edge, then release start.
  task automatic issue(input logic [3:0] o, input logic [31:0] a, input logic [31:0] b);
    op    = o;
    A     = a;
    B     = b;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    op    = NONE;
  endtask

  // Count negedges with busy high; bounded so a stuck unit cannot hang the run.
  task automatic wait_idle(output int n);
    n = 0;
    @(negedge clk);
    while (busy && n < 100) begin
      n++;
      @(negedge clk);
    end
  endtask

  task automatic pop_check(input int n);
    exp_t e;
    if (sb.size() == 0) begin
      n_cmp++;
      n_err++;
      $display("FAIL scoreboard: queue empty, expected an entry");
      return;
    end
    e = sb.pop_front();
    check({e.name, " latency"}, 32'(n), 32'(e.lat));
    check({e.name, " HI"}, HI, e.hi);
    check({e.name, " LO"}, LO, e.lo);
  endtask

  initial begin
    int n;

    vecs[0]  = '{"mult -2*3", MULT, 32'hFFFF_FFFE, 32'd3, 32'd0, 32'd0,
                 32'hFFFF_FFFF, 32'hFFFF_FFFA, 5};
    vecs[1]  = '{"multu max*max", MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd0, 32'd0,
                 32'hFFFF_FFFE, 32'h0000_0001, 5};
    vecs[2]  = '{"mult min*min", MULT, 32'h8000_0000, 32'h8000_0000, 32'd0, 32'd0,
                 32'h4000_0000, 32'h0000_0000, 5};
    vecs[3]  = '{"div -7/2", DIV, 32'hFFFF_FFF9, 32'd2, 32'd0, 32'd0,
                 32'hFFFF_FFFF, 32'hFFFF_FFFD, 10};
    vecs[4]  = '{"divu 7/0", DIVU, 32'd7, 32'd0, 32'hAAAA_0000, 32'h0000_5555,
                 32'hAAAA_0000, 32'h0000_5555, 10};
    vecs[5]  = '{"div overflow", DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'h1, 32'h2,
                 32'h0000_0000, 32'h8000_0000, 10};
    vecs[6]  = '{"divu max/16", DIVU, 32'hFFFF_FFFF, 32'd16, 32'd0, 32'd0,
                 32'h0000_000F, 32'h0FFF_FFFF, 10};
    vecs[7]  = '{"div 7/-2", DIV, 32'd7, 32'hFFFF_FFFE, 32'd0, 32'd0,
                 32'h0000_0001, 32'hFFFF_FFFD, 10};
    vecs[8]  = '{"mthi", MTHI, 32'h1234_5678, 32'd0, 32'd0, 32'h0BAD_F00D,
                 32'h1234_5678, 32'h0BAD_F00D, 0};
    vecs[9]  = '{"mtlo", MTLO, 32'hCAFE_BABE, 32'd0, 32'h1111_2222, 32'd0,
                 32'h1111_2222, 32'hCAFE_BABE, 0};
    vecs[10] = '{"unknown op", 4'd15, 32'd9, 32'd9, 32'h3, 32'h4, 32'h3, 32'h4, 0};
    if (MaddEn) begin
      vecs[11] = '{"maddu", MADDU, 32'd1, 32'd1, 32'd0, 32'hFFFF_FFFF,
                   32'h0000_0001, 32'h0000_0000, 5};
      vecs[12] = '{"msub", MSUB, 32'd1, 32'd1, 32'd0, 32'd0,
                   32'hFFFF_FFFF, 32'hFFFF_FFFF, 5};
    end else begin
      vecs[11] = '{"maddu", MADDU, 32'd1, 32'd1, 32'd0, 32'hFFFF_FFFF,
                   32'h0000_0000, 32'hFFFF_FFFF, 0};
      vecs[12] = '{"msub", MSUB, 32'd1, 32'd1, 32'd0, 32'd0,
                   32'h0000_0000, 32'h0000_0000, 0};
    end

    reset  = 1'b1;
    start  = 1'b0;
    cancel = 1'b0;
    op     = NONE;
    A      = '0;
    B      = '0;
    #12;
    check("reset busy", 32'(busy), 32'd0);
    check("reset HI", HI, 32'd0);
    check("reset LO", LO, 32'd0);
    check("reset MD", MD, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);

    foreach (vecs[i]) begin
      issue(MTHI, vecs[i].pre_hi, 32'd0);
      issue(MTLO, vecs[i].pre_lo, 32'd0);
      sb.push_back('{vecs[i].name, vecs[i].exp_hi, vecs[i].exp_lo, vecs[i].lat});
      issue(vecs[i].op, vecs[i].a, vecs[i].b);
      wait_idle(n);
      pop_check(n);
    end

    // MD mux follows op combinationally.
    issue(MTHI, 32'h1234_5678, 32'd0);
    issue(MTLO, 32'h0BAD_F00D, 32'd0);
    op = MFHI;
    #1;
    check("md mfhi", MD, 32'h1234_5678);
    op = MFLO;
    #1;
    check("md mflo", MD, 32'h0BAD_F00D);
    op = NONE;
    @(negedge clk);

    // Starts while busy (mid-run and on the final busy cycle) are dropped.
    sb.push_back('{"multu while busy", 32'd0, 32'd15, 5});
    issue(MULTU, 32'd3, 32'd5);
    n = 0;
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      if (!busy) break;
      n++;
      start = (n == 2) || (n == 5);
      op    = (n == 5) ? MTHI : MULT;
      A     = (n == 5) ? 32'h0000_DEAD : 32'hFFFF_FFFF;
      B     = 32'd2;
    end
    start = 1'b0;
    op    = NONE;
    pop_check(n);
    @(negedge clk);
    check("late mthi dropped", HI, 32'd0);

    // Cancel suppresses the start entirely.
    issue(MTHI, 32'h0000_A5A5, 32'd0);
    issue(MTLO, 32'h0000_5A5A, 32'd0);
    sb.push_back('{"cancelled mult", 32'h0000_A5A5, 32'h0000_5A5A, 0});
    cancel = 1'b1;
    issue(MULT, 32'd7, 32'd9);
    cancel = 1'b0;
    wait_idle(n);
    pop_check(n);

    // Asynchronous reset during a divide clears state without a clock edge.
    issue(MTHI, 32'h0000_1111, 32'd0);
    issue(MTLO, 32'h0000_2222, 32'd0);
    issue(DIV, 32'd100, 32'd7);
    repeat (3) @(negedge clk);
    check("div running", 32'(busy), 32'd1);
    #1;
    reset = 1'b1;
    #1;
    check("async rst busy", 32'(busy), 32'd0);
    check("async rst HI", HI, 32'd0);
    check("async rst LO", LO, 32'd0);
    #1;
    reset = 1'b0;
    repeat (12) @(negedge clk);
    check("post rst busy", 32'(busy), 32'd0);
    check("post rst HI", HI, 32'd0);
    check("post rst LO", LO, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/mdu.md
Name: mdu

Overview:
- Multiply/divide unit in the E stage of the 5-stage MIPS pipeline.
- Executes mult/multu/div/divu/mthi/mtlo and holds the HI/LO registers.
- Drives the MD value that the E/M pipeline register captures for mfhi/mflo.
- Raises busy so the hazard unit stalls dependent MDU instructions in D.

Parameters:
- MULT_LAT, 5: cycles busy stays high after a mult/multu start.
- DIV_LAT, 10: cycles busy stays high after a div/divu start.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-high; clears all state immediately.
- start  input  1  E-stage instruction is a valid MDU op this cycle.
- op  input  4  MDU operation code (encoding in constants.v).
- cancel  input  1  exception or interrupt flush; suppresses any start in the same cycle.
- A  input  32  rs operand (forwarded).
- B  input  32  rt operand (forwarded).
- busy  output  1  computation in progress.
- MD  output  32  LO when op==MFLO, else HI; combinational.
- HI  output  32  HI register.
- LO  output  32  LO register.

Behaviour:
- Reset: busy=0, HI=0, LO=0, counter=0, result temporaries=0. Reset asynchronous, active-high, applies mid-operation: the computation is abandoned and HI/LO are cleared.
- Accepted start: start=1, cancel=0, busy=0.
- Start while busy: ignored. The hazard unit must stall instead; the unit does not queue.
- Start with cancel=1: no state change.
- MULT/MULTU accepted:
  - Full 64-bit signed/unsigned product latched into tmp_hi/tmp_lo.
  - counter loaded with MULT_LAT; busy=1 from the next cycle.
- DIV/DIVU accepted:
  - tmp_lo = quotient, tmp_hi = remainder; counter loaded with DIV_LAT.
  - Signed division truncates toward zero; remainder takes the sign of the dividend.
  - Signed 0x80000000 / 0xFFFFFFFF gives LO=0x80000000, HI=0.
  - Divide by zero (B==0): busy still runs the full DIV_LAT; HI/LO left unchanged at completion.
- Busy phase:
  - Counter decrements each cycle while >0.
  - On the edge where the counter goes 1->0: HI<=tmp_hi, LO<=tmp_lo, busy<=0.
  - Total latency: start at edge N, busy high for the following LAT cycles, results visible at edge N+LAT.
- MTHI/MTLO accepted: HI (or LO) <= A at the next edge; busy stays 0; no latency.
- MFHI/MFLO: no state change; MD reflects the current registers combinationally. Stall logic guarantees they are never issued while busy.
- Unknown op with start=1: no effect.
- busy falls in the same cycle a new start arrives: the start sees busy=1 and is ignored.

Optional Feature:
- Macro: MDU_MADD_EN.
- Defined: op codes MADD/MADDU/MSUB/MSUBU are accepted with MULT_LAT latency.
  - Result is {HI,LO} +/- product (signed or unsigned), 64-bit wrap-around.
  - The base {HI,LO} is sampled at the start edge.
- Undefined: these codes are treated as unknown ops and ignored.

Decomposition:
- constants.v carries the op encoding as `define: MDU_NONE 0, MULT 1, MULTU 2, DIV 3, DIVU 4, MTHI 5, MTLO 6, MFHI 7, MFLO 8, MADD 9, MADDU 10, MSUB 11, MSUBU 12.
- constants.v also carries the default MULT_LAT/DIV_LAT values.
- No sub-module. Counter, temporaries and HI/LO live in one always block, with a separate combinational MD mux.

Test Plan:
1. Reset, then MULT A=0xFFFFFFFE (-2), B=3 -> busy high 5 cycles; then HI=0xFFFFFFFF, LO=0xFFFFFFFA.
2. DIV A=0xFFFFFFF9 (-7), B=2 -> busy 10 cycles; LO=0xFFFFFFFD, HI=0xFFFFFFFF. DIVU A=7, B=0 -> busy 10 cycles, HI/LO unchanged.
3. MTHI A=0x12345678 with start=1 -> HI=0x12345678 next edge, busy stays 0; op=MFHI -> MD=0x12345678.
4. MULTU started; second MULT asserted mid-busy -> ignored; HI/LO hold the first product only, busy falls after exactly 5 cycles.
5. Start MULT with cancel=1 -> busy stays 0, HI/LO unchanged. Async reset pulse at cycle 3 of a DIV -> busy=0, HI=LO=0 immediately, without waiting for a clk edge.
6. MDU_MADD_EN defined: HI=0, LO=0xFFFFFFFF, MADDU A=1, B=1 -> after 5 cycles HI=1, LO=0. Macro undefined: same stimulus -> no change.
